uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides: FSM state encoding,
// frame width and the baud divisor helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // Clock cycles per line bit, truncated toward zero.
   function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                input int unsigned uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; show-ahead read (rd_data valid while rd_en is high).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 empty,
   output logic                 full
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic [AW:0]          count_d;
   logic                 wr_ok;
   logic                 rd_ok;

   // A write into a full FIFO is still taken when a pop frees a slot in the same cycle.
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_d = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count + (AW+1)'(1);
         2'b01:   count_d = count - (AW+1)'(1);
         default: count_d = count;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_d;
         full  <= (count_d == (AW+1)'(FIFO_DEPTH));
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with byte FIFO: 8N1 frames, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
module uart_tx
   import uart_pkg::*;
#(
   parameter logic [19:0] UART_BPS   = 20'd115200,
   parameter logic [25:0] CLK_FREQ   = 26'd50_000_000,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [DATA_BITS-1:0] pi_data,
   input  logic                 pi_flag,
   output logic                 tx,
   output logic                 busy,
   output logic                 fifo_full,
   output logic                 overflow
);

   localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(32'(CLK_FREQ), 32'(UART_BPS));
   localparam int          BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
   localparam int          BIT_W        = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   uart_state_e          state_q;
   uart_state_e          state_d;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 bit_end;
   logic                 pop;
   logic                 tx_d;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   assign bit_end = (baud_cnt == BAUD_LAST);

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .wr_en     (pi_flag),
      .wr_data   (pi_data),
      .rd_en     (pop),
      .rd_data   (fifo_rd_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d = shift_reg[0];
            if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_d = parity_q;
            if (bit_end) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The baud counter is held at zero in IDLE, so every START begins a fresh bit time.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (state_q == IDLE || bit_end) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
         end

         if (pop) begin
            shift_reg <= fifo_rd_data;
         end else if (state_q == DATA && bit_end) begin
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
         end

         if (state_q == IDLE) begin
            bit_cnt <= '0;
         end else if (state_q == DATA && bit_end) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         parity_q <= 1'b0;
      end else if (pop) begin
         parity_q <= ^fifo_rd_data;
      end
   end
`endif

   // Line and status outputs come straight from flops so tx never glitches.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx       <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         tx       <= tx_d;
         busy     <= (state_q != IDLE) || !fifo_empty;
         overflow <= pi_flag && fifo_full && !pop;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: exact line timing for single bytes, plus a line
// decoder feeding a scoreboard of written bytes for burst, overflow and reset cases.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam logic [25:0] CLK_FREQ   = 26'd1_000_000;
   localparam logic [19:0] UART_BPS   = 20'd90_000;
   localparam int          FIFO_DEPTH = 16;
   localparam int          B          = 11;
`ifdef UART_TX_PARITY_EN
   localparam int          NB         = 11;
`else
   localparam int          NB         = 10;
`endif
   localparam int          F          = NB * B;

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
      logic       par;
   } vec_t;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic       pi_flag   = 1'b0;
   logic [7:0] pi_data   = 8'h00;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   int         cyc   = 0;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         fall_q[$];

   uart_tx #(
      .UART_BPS   (UART_BPS),
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pi_data   (pi_data),
      .pi_flag   (pi_flag),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Called on a negedge; returns on the next negedge with edge_k = the sampling edge.
   task automatic applyStimulus(input logic [7:0] data, input bit expect_tx, output int edge_k);
      pi_data = data;
      pi_flag = 1'b1;
      if (expect_tx) exp_q.push_back(data);
      @(negedge sys_clk);
      edge_k  = cyc;
      pi_flag = 1'b0;
   endtask

   task automatic waitIdle(input int max_cyc, output int drop_cyc, output bit full_seen);
      drop_cyc  = -1;
      full_seen = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         if (fifo_full) full_seen = 1'b1;
         if (!busy) begin
            drop_cyc = cyc;
            break;
         end
         @(negedge sys_clk);
      end
   endtask

   function automatic logic expBit(input vec_t v, input int b);
`ifdef UART_TX_PARITY_EN
      if (b == 9)  return v.par;
      if (b == 10) return v.line[9];
`endif
      return v.line[b];
   endfunction

   // Line decoder: samples each bit mid-way and checks it against the scoreboard.
   initial begin : monitor
      logic          prev;
      logic [NB-1:0] bits;
      logic [7:0]    exp;
      bit            aborted;
      prev = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n && prev && !tx) begin
            fall_q.push_back(cyc);
            bits    = '0;
            bits[0] = 1'b0;
            aborted = 1'b0;
            for (int c = 1; c <= (NB - 1) * B + B / 2; c++) begin
               @(negedge sys_clk);
               if (!sys_rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (c % B == B / 2) bits[c / B] = tx;
            end
            if (!aborted) begin
               checkOutput("frame_was_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  checkOutput("rx_start_bit", bits[0], 1'b0);
                  checkOutput("rx_data", bits[8:1], exp);
`ifdef UART_TX_PARITY_EN
                  checkOutput("rx_parity_bit", bits[9], ^exp);
`endif
                  checkOutput("rx_stop_bit", bits[NB-1], 1'b1);
               end
            end
         end
         prev = tx;
      end
   end

   initial begin : watchdog
      #1_000_000;
      n_vec++;
      n_err++;
      $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : stimulus
      vec_t vecs[4];
      int   k;
      int   t;
      int   drop;
      bit   full_seen;
      bit   quiet_bad;
      bit   busy_bad;

      vecs[0] = '{8'h55, 10'h2AA, 1'b0};
      vecs[1] = '{8'h07, 10'h20E, 1'b1};
      vecs[2] = '{8'hA3, 10'h346, 1'b0};
      vecs[3] = '{8'h5C, 10'h2B8, 1'b0};

      #2 sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset_tx", tx, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_fifo_full", fifo_full, 1'b0);
      checkOutput("reset_overflow", overflow, 1'b0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Single bytes with exact bit boundaries, latency and busy release.
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].data, 1'b1, k);
         checkOutput($sformatf("v%0d_tx_at_write", v), tx, 1'b1);
         @(negedge sys_clk);
         checkOutput($sformatf("v%0d_tx_at_pop", v), tx, 1'b1);
         checkOutput($sformatf("v%0d_busy_at_pop", v), busy, 1'b1);
         for (int j = 0; j < F; j++) begin
            @(negedge sys_clk);
            if (j % B == 0 || j % B == B - 1)
               checkOutput($sformatf("v%0d_line_bit%0d_c%0d", v, j / B, j % B), tx, expBit(vecs[v], j / B));
         end
         checkOutput($sformatf("v%0d_busy_last_cycle", v), busy, 1'b1);
         @(negedge sys_clk);
         checkOutput($sformatf("v%0d_tx_after_frame", v), tx, 1'b1);
         checkOutput($sformatf("v%0d_busy_dropped", v), busy, 1'b0);
         repeat (3) @(negedge sys_clk);
      end

      // Burst of three bytes on consecutive cycles.
      fall_q.delete();
      applyStimulus(8'h01, 1'b1, k);
      applyStimulus(8'h80, 1'b1, t);
      applyStimulus(8'hFF, 1'b1, t);
      waitIdle(3 * F + 40, drop, full_seen);
      checkOutput("burst_busy_drop_edge", drop - k, 3 * F + 4);
      checkOutput("burst_fifo_full_seen", full_seen, 1'b0);
      checkOutput("burst_frame_count", fall_q.size(), 3);
      if (fall_q.size() == 3) begin
         checkOutput("burst_first_fall", fall_q[0] - k, 2);
         checkOutput("burst_gap_1_2", fall_q[1] - fall_q[0], F + 1);
         checkOutput("burst_gap_2_3", fall_q[2] - fall_q[1], F + 1);
      end
      checkOutput("burst_scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge sys_clk);

      // 18 writes into a 16-deep FIFO: the last one is dropped.
      fall_q.delete();
      for (int i = 0; i < 18; i++) begin
         applyStimulus(8'(i), i < 17, t);
         if (i == 0) k = t;
         checkOutput($sformatf("ovf_fifo_full_w%0d", i), fifo_full, i >= 16);
         checkOutput($sformatf("ovf_pulse_w%0d", i), overflow, i == 17);
      end
      checkOutput("ovf_last_edge", t - k, 17);
      @(negedge sys_clk);
      checkOutput("ovf_pulse_single_cycle", overflow, 1'b0);
      checkOutput("ovf_full_holds", fifo_full, 1'b1);
      waitIdle(17 * (F + 1) + 50, drop, full_seen);
      checkOutput("ovf_drained", drop >= 0, 1'b1);
      checkOutput("ovf_frame_count", fall_q.size(), 17);
      checkOutput("ovf_scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge sys_clk);

      // Reset during data bit 3 of the first of two queued frames.
      applyStimulus(8'hF0, 1'b1, k);
      applyStimulus(8'h0F, 1'b1, t);
      while (cyc < k + 2 + 4 * B + B / 2) @(negedge sys_clk);
      checkOutput("rst_tx_before", tx, 1'b0);
      sys_rst_n = 1'b0;
      #1;
      checkOutput("rst_tx_immediate", tx, 1'b1);
      checkOutput("rst_busy_immediate", busy, 1'b0);
      checkOutput("rst_fifo_full_immediate", fifo_full, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      quiet_bad = 1'b0;
      busy_bad  = 1'b0;
      for (int c = 0; c < 10 * B + 10; c++) begin
         @(negedge sys_clk);
         if (tx !== 1'b1) quiet_bad = 1'b1;
         if (busy !== 1'b0) busy_bad = 1'b1;
      end
      checkOutput("post_reset_line_quiet", quiet_bad, 1'b0);
      checkOutput("post_reset_not_busy", busy_bad, 1'b0);

      checkOutput("final_scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
